sector_pump_scheduler: RTL

SECTOR_PUMP_SCHEDULER -- requirements
Module: sector_pump_scheduler

---
 rtl/sector_pump_pkg.sv | 10 +
 rtl/sector_req_fifo.sv | 39 +++
 rtl/sector_pump_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/sector_pump_pkg.sv
// sector_pump_pkg: shared states and address geometry for the sector pump scheduler.
package sector_pump_pkg;
    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
    localparam int SECTOR_BYTES = 512;
    localparam int HALF_WORDS   = 512;
    localparam int SECTOR_W     = 6;
    localparam int OFFSET_W     = $clog2(SECTOR_BYTES);
    localparam int RADDR_W      = SECTOR_W + OFFSET_W;
    localparam int WADDR_W      = 10;
endpackage

// File: rtl/sector_req_fifo.sv
// sector_req_fifo: power-of-two request queue of sector indices.
module sector_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr, rd;
    // a push alongside a pop is safe even when full
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[rp];
    always_ff @(posedge CLK)
        if (wr) mem[wp] <= din;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/sector_pump_scheduler.sv
// sector_pump_scheduler: queues sector requests and sequences the pumper into
// alternating write-buffer halves with settle, guard and timeout handling.
module sector_pump_scheduler
    import sector_pump_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int SETTLE  = 3,
    parameter int GUARD   = 4,
    parameter int TIMEOUT = 1100
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    input  logic [SECTOR_W-1:0] REQ_SECTOR,
    output logic                REQ_READY,
    output logic                PUMP_ENA,
    output logic [RADDR_W-1:0]  START_RADDR,
    output logic [WADDR_W-1:0]  START_WADDR,
    output logic                BUFREADY,
    input  logic                COMPLT_PUMPER,
    output logic [1:0]          HALF_FULL,
    input  logic [1:0]          HALF_RELEASE,
    output logic                BUSY,
    output logic                ERR
);
    localparam int CW = $clog2(TIMEOUT + SETTLE + GUARD + 2);
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [SECTOR_W-1:0] head;
    logic [1:0] set;
    logic tgt, complt_q, pop, full, empty, done, tout, settled;

    sector_req_fifo #(.DEPTH(QDEPTH), .W(SECTOR_W)) u_fifo (
        .CLK(CLK), .RST(RST), .push(REQ_VALID && REQ_READY), .pop(pop),
        .din(REQ_SECTOR), .dout(head), .full(full), .empty(empty)
    );

    assign REQ_READY = !full;
    assign PUMP_ENA = state == RUN;
    assign BUSY = state != IDLE;
    assign ERR = tout;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    // completion is honoured only if it was sampled after the guard window
    assign done = state == RUN && complt_q && cnt > CW'(GUARD + 1);
    assign tout = state == RUN && !done && cnt >= CW'(TIMEOUT);
    assign settled = cnt == CW'(SETTLE - 1);
    assign set = done ? (tgt ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nxt = state;
        cnt_nxt = state == IDLE ? '0 : cnt_inc;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty && !HALF_FULL[tgt]) begin
                pop = 1'b1;
                state_nxt = ARM;
            end
            ARM: if (settled) begin
                state_nxt = RUN;
                cnt_nxt = CW'(1);
            end
            RUN: if (done || tout) begin
                state_nxt = DRAIN;
                cnt_nxt = '0;
            end
            default: if (settled) begin
                state_nxt = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            tgt <= 1'b0;
            complt_q <= 1'b0;
            HALF_FULL <= 2'b00;
            START_RADDR <= '0;
            START_WADDR <= '0;
            BUFREADY <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            tgt <= tgt ^ done;
            complt_q <= COMPLT_PUMPER;
            HALF_FULL <= (HALF_FULL & ~HALF_RELEASE) | set;
            if (pop) begin
                START_RADDR <= {head, {OFFSET_W{1'b0}}};
                START_WADDR <= tgt ? WADDR_W'(HALF_WORDS) : '0;
                BUFREADY <= !tgt;
            end
        end
    end
endmodule
